upd_7800: RTL and testbench
===========================

# upd_7800

Timer/interval-interrupt core of the uPD7800 CPU: a 12-bit down-counter with a 3-bit prescaler, a reload register, the INTFT request flag and its SKIT test. It runs from the CPU master clock, advances on the CP2 falling-phase enable, and feeds the CPU interrupt controller and skip logic. The CPU sequencer drives its register-write and strobe inputs.

## Interface
- No parameters.
- CLK  in  1  master clock; all state changes on rising edge.
- RESETB  in  1  asynchronous active-low reset.
- CP1_POSEDGE, CP1_NEGEDGE, CP2_POSEDGE, CP2_NEGEDGE  in  1 each  one-hot phase enables, cycling in that order, one CLK each; one CP cycle = 4 CLK.
- TM_WE  in  1  load reload register from TM_D.
- TM_D  in  12  reload value.
- STM  in  1  one-CLK strobe from the STM instruction: restart the timer.
- SKIT_INTFT  in  1  one-CLK strobe from SKIT INTFT: test-and-clear INTFT.
- RESG  out  1  synchronized internal reset; high while held in reset.
- TC  out  15  timer state: [14:3] counter, [2:0] prescaler.
- TC_UF  out  1  underflow pulse.
- INTFT  out  1  timer interrupt request flag.
- SKIP  out  1  skip result of SKIT_INTFT, valid the CLK after the strobe.

## Operation
- Reset (RESETB low, asynchronous): TM=0xFFF, TC=0x7FFF (counter 0xFFF, prescaler 7), TC_UF=0, INTFT=0, SKIP=0, RESG=1.
- RESG release: RESETB passes through two CLK flops; RESG falls on the second rising edge after RESETB rises. Assertion of RESETB sets RESG immediately. While RESG=1, TC holds its reset value.
- Tick: a CLK with CP2_NEGEDGE=1 and RESG=0, so one tick every 0.5 us at 8 MHz CLK.
- On a tick with TC≠0: TC decrements by 1 as a 15-bit value. The prescaler counts 7→0, then wraps to 7 and borrows from the counter, so the counter decrements every 8 ticks (4 us).
- On a tick with TC==0: TC holds and TC_UF is set.
- CLK after TC_UF=1: TC={TM,3'd7}, TC_UF cleared, INTFT set. TC_UF is exactly one CLK wide.
- STM: TC={TM,3'd7} on the next edge, TC_UF cleared. STM takes priority over a coincident tick or reload.
- TM_WE: writes TM only and does not disturb TC. If TM_WE and STM occur in the same CLK, STM loads the new TM_D.
- SKIT_INTFT: SKIP <= INTFT and INTFT <= 0 in the same edge. If an underflow set occurs in the same CLK, the set wins, INTFT stays 1 and SKIP=1. SKIP holds until the next SKIT_INTFT.

## Timing
- Prescaler change is visible one CLK after the CP2_NEGEDGE cycle.
- Underflow to INTFT: 2 CLK after the tick that finds TC==0. TC stays 0 during the TC_UF CLK.
- Full period with TM=N: (N+1)*8 ticks from reload to next underflow, e.g. 0xFFF gives 32768 ticks.
- No tick is consumed by the reload CLK. The reload CLK is never a CP2_NEGEDGE cycle because that enable recurs only every 4 CLK.

## Test plan
- Reset: hold RESETB low, then check TC=0x7FFF, INTFT=0, TC_UF=0. Release and check RESG falls after 2 CLK with TC unchanged until the first tick.
- Prescaler/counter: free-run. Check TC[2:0]=6 after 1 tick, and counter=0xFFE with prescaler=7 after 8 ticks (4 us).
- Underflow: force counter=0 with prescaler=7. After 7 ticks TC=0 and TC_UF=0. On the next tick TC_UF=1 with TC=0. One CLK later TC=0x7FFF, TC_UF=0, INTFT=1.
- SKIT: with INTFT=1, pulse SKIT_INTFT and check INTFT=0, SKIP=1. Pulse again and check SKIP=0.
- STM: write TM=0x0F9, pulse STM mid-count and check TC={0x0F9,7}. Run 8 ticks and check counter=0x0F8, prescaler=7.
- Simultaneity: STM coincident with an underflow tick gives a reload with TC_UF=0. SKIT coincident with the INTFT set leaves INTFT=1.

Source files
------------

// File: rtl/upd_7800.sv
// uPD7800 timer / interval-interrupt core: 12-bit down-counter with 3-bit prescaler,
// reload register TM, INTFT request flag and the SKIT INTFT test-and-clear.
module upd_7800 (
    input  logic        CLK,
    input  logic        RESETB,
    input  logic        CP1_POSEDGE,
    input  logic        CP1_NEGEDGE,
    input  logic        CP2_POSEDGE,
    input  logic        CP2_NEGEDGE,
    input  logic        TM_WE,
    input  logic [11:0] TM_D,
    input  logic        STM,
    input  logic        SKIT_INTFT,
    output logic        RESG,
    output logic [14:0] TC,
    output logic        TC_UF,
    output logic        INTFT,
    output logic        SKIP
);

    logic [1:0]  sync_q, sync_d;
    logic [11:0] tm_q, tm_d;
    logic [14:0] tc_q, tc_d;
    logic        tc_uf_q, tc_uf_d;
    logic        intft_q, intft_d;
    logic        skip_q, skip_d;
    logic        resg;
    logic        phase_ok;
    logic        tick;
    logic        intft_set;

    // The tick enable is only honoured when the phase enables are one-hot.
    assign phase_ok = CP2_NEGEDGE & ~CP1_POSEDGE & ~CP1_NEGEDGE & ~CP2_POSEDGE;
    assign resg     = ~sync_q[1];
    assign tick     = phase_ok & ~resg;

    always_comb begin
        sync_d    = {sync_q[0], 1'b1};
        tm_d      = TM_WE ? TM_D : tm_q;
        tc_d      = tc_q;
        tc_uf_d   = 1'b0;
        intft_set = tc_uf_q;

        if (resg) begin
            tc_d = 15'h7FFF;
        end else if (STM) begin
            // STM sees a coincident TM write, so it reloads from the new value.
            tc_d = {tm_d, 3'd7};
        end else if (tc_uf_q) begin
            tc_d = {tm_q, 3'd7};
        end else if (tick) begin
            if (tc_q != 15'd0) begin
                tc_d = tc_q - 15'd1;
            end else begin
                tc_uf_d = 1'b1;
            end
        end

        // An INTFT set in the same CLK as SKIT wins and is reported as a skip.
        intft_d = intft_set | (intft_q & ~SKIT_INTFT);
        skip_d  = SKIT_INTFT ? (intft_q | intft_set) : skip_q;
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            sync_q  <= 2'b00;
            tm_q    <= 12'hFFF;
            tc_q    <= 15'h7FFF;
            tc_uf_q <= 1'b0;
            intft_q <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            tm_q    <= tm_d;
            tc_q    <= tc_d;
            tc_uf_q <= tc_uf_d;
            intft_q <= intft_d;
            skip_q  <= skip_d;
        end
    end

    assign RESG  = resg;
    assign TC    = tc_q;
    assign TC_UF = tc_uf_q;
    assign INTFT = intft_q;
    assign SKIP  = skip_q;

endmodule

// File: tb/tb_upd_7800.sv
// Bench for upd_7800: directed vector table, hand-written corner sequences and
// randomized traffic checked against an integer-level timer model.
module tb_upd_7800;

    logic        CLK = 1'b0;
    logic        RESETB;
    logic        cp1p, cp1n, cp2p, cp2n;
    logic        TM_WE;
    logic [11:0] TM_D;
    logic        STM;
    logic        SKIT;
    logic        RESG;
    logic [14:0] TC;
    logic        TC_UF;
    logic        INTFT;
    logic        SKIP;

    int total = 0;
    int bad   = 0;
    int p     = 0;

    // Reference model state: TC as one integer 0..32767.
    int m_tc, m_tm, m_rel;
    bit m_uf, m_intft, m_skip;

    upd_7800 dut (
        .CLK        (CLK),
        .RESETB     (RESETB),
        .CP1_POSEDGE(cp1p),
        .CP1_NEGEDGE(cp1n),
        .CP2_POSEDGE(cp2p),
        .CP2_NEGEDGE(cp2n),
        .TM_WE      (TM_WE),
        .TM_D       (TM_D),
        .STM        (STM),
        .SKIT_INTFT (SKIT),
        .RESG       (RESG),
        .TC         (TC),
        .TC_UF      (TC_UF),
        .INTFT      (INTFT),
        .SKIP       (SKIP)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       nm;
        bit          stm;
        bit          we;
        logic [11:0] d;
        bit          skit;
        int          ticks;
        logic [14:0] tc;
        bit          uf;
        bit          intft;
        bit          skip;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic model_rst();
        m_tc    = 32767;
        m_tm    = 4095;
        m_uf    = 1'b0;
        m_intft = 1'b0;
        m_skip  = 1'b0;
        m_rel   = 0;
    endtask

    task automatic model_edge();
        bit resg, tick, set;
        int ntm, ntc;
        bit nuf;
        if (!RESETB) begin
            model_rst();
        end else begin
            resg = (m_rel < 2);
            tick = (p == 3) && !resg;
            ntm  = TM_WE ? int'(TM_D) : m_tm;
            ntc  = m_tc;
            nuf  = 1'b0;
            if (resg)            ntc = 32767;
            else if (STM)        ntc = ntm * 8 + 7;
            else if (m_uf)       ntc = m_tm * 8 + 7;
            else if (tick) begin
                if (m_tc > 0) ntc = m_tc - 1;
                else          nuf = 1'b1;
            end
            set     = m_uf;
            m_skip  = SKIT ? (m_intft | set) : m_skip;
            m_intft = set ? 1'b1 : (SKIT ? 1'b0 : m_intft);
            m_tc    = ntc;
            m_tm    = ntm;
            m_uf    = nuf;
            if (m_rel < 2) m_rel++;
        end
    endtask

    task automatic step();
        cp1p = (p == 0);
        cp1n = (p == 1);
        cp2p = (p == 2);
        cp2n = (p == 3);
        @(posedge CLK);
        model_edge();
        #1;
        STM   = 1'b0;
        TM_WE = 1'b0;
        SKIT  = 1'b0;
        p     = (p + 1) % 4;
    endtask

    task automatic run_ticks(input int n);
        int k = 0;
        while (k < n) begin
            bit t;
            t = (p == 3);
            step();
            if (t) k++;
        end
    endtask

    initial begin
        RESETB = 1'b1;
        TM_WE = 1'b0; TM_D = 12'h000; STM = 1'b0; SKIT = 1'b0;
        cp1p = 1'b0; cp1n = 1'b0; cp2p = 1'b0; cp2n = 1'b0;
        model_rst();
        #2;
        RESETB = 1'b0;

        vt[0]  = '{"tick1",      0, 0, 12'h000, 0, 1, 15'h7FFE, 0, 0, 0};
        vt[1]  = '{"tick8",      0, 0, 12'h000, 0, 7, 15'h7FF7, 0, 0, 0};
        vt[2]  = '{"stm_tm0",    1, 1, 12'h000, 0, 0, 15'h0007, 0, 0, 0};
        vt[3]  = '{"count_to0",  0, 1, 12'hFFF, 0, 7, 15'h0000, 0, 0, 0};
        vt[4]  = '{"uf_tick",    0, 0, 12'h000, 0, 1, 15'h0000, 1, 0, 0};
        vt[5]  = '{"reload",     0, 0, 12'h000, 0, 0, 15'h7FFF, 0, 1, 0};
        vt[6]  = '{"skit1",      0, 0, 12'h000, 1, 0, 15'h7FFF, 0, 0, 1};
        vt[7]  = '{"skit2",      0, 0, 12'h000, 1, 0, 15'h7FFF, 0, 0, 0};
        vt[8]  = '{"midcount",   0, 0, 12'h000, 0, 3, 15'h7FFC, 0, 0, 0};
        vt[9]  = '{"we_stm_0f9", 1, 1, 12'h0F9, 0, 0, 15'h07CF, 0, 0, 0};
        vt[10] = '{"run8_0f8",   0, 0, 12'h000, 0, 8, 15'h07C7, 0, 0, 0};
        vt[11] = '{"we_only",    0, 1, 12'h123, 0, 0, 15'h07C7, 0, 0, 0};
        vt[12] = '{"stm_123",    1, 0, 12'h000, 0, 0, 15'h091F, 0, 0, 0};
        vt[13] = '{"tick_123",   0, 0, 12'h000, 0, 1, 15'h091E, 0, 0, 0};

        // Reset hold and release
        repeat (3) step();
        chk("rst_tc",    32'(TC),    32'h7FFF);
        chk("rst_uf",    32'(TC_UF), 32'h0);
        chk("rst_intft", 32'(INTFT), 32'h0);
        chk("rst_skip",  32'(SKIP),  32'h0);
        chk("rst_resg",  32'(RESG),  32'h1);
        RESETB = 1'b1;
        step();
        chk("resg_edge1", 32'(RESG), 32'h1);
        step();
        chk("resg_edge2", 32'(RESG), 32'h0);
        chk("resg_tc",    32'(TC),   32'h7FFF);

        for (int i = 0; i < 14; i++) begin
            STM   = vt[i].stm;
            TM_WE = vt[i].we;
            TM_D  = vt[i].d;
            SKIT  = vt[i].skit;
            if (vt[i].stm || vt[i].we || vt[i].skit || vt[i].ticks == 0) step();
            run_ticks(vt[i].ticks);
            chk({vt[i].nm, "_tc"},    32'(TC),    32'(vt[i].tc));
            chk({vt[i].nm, "_uf"},    32'(TC_UF), 32'(vt[i].uf));
            chk({vt[i].nm, "_intft"}, 32'(INTFT), 32'(vt[i].intft));
            chk({vt[i].nm, "_skip"},  32'(SKIP),  32'(vt[i].skip));
        end

        // STM on the tick that finds TC==0: reload, no underflow, no INTFT
        TM_WE = 1'b1; TM_D = 12'h000; STM = 1'b1;
        step();
        run_ticks(7);
        chk("pre_stm_uf_tc", 32'(TC), 32'h0);
        while (p != 3) step();
        TM_WE = 1'b1; TM_D = 12'h055; STM = 1'b1;
        step();
        chk("stm_uf_tc", 32'(TC),    32'h02AF);
        chk("stm_uf_uf", 32'(TC_UF), 32'h0);
        step();
        chk("stm_uf_intft", 32'(INTFT), 32'h0);
        chk("stm_uf_tc2",   32'(TC),    32'h02AF);

        // SKIT in the same CLK as the INTFT set
        TM_WE = 1'b1; TM_D = 12'h000; STM = 1'b1;
        step();
        run_ticks(8);
        chk("skit_set_pre_uf", 32'(TC_UF), 32'h1);
        SKIT = 1'b1;
        step();
        chk("skit_set_intft", 32'(INTFT), 32'h1);
        chk("skit_set_skip",  32'(SKIP),  32'h1);
        chk("skit_set_tc",    32'(TC),    32'h0007);
        SKIT = 1'b1;
        step();
        chk("skit_after_intft", 32'(INTFT), 32'h0);
        chk("skit_after_skip",  32'(SKIP),  32'h1);

        // Asynchronous reset assertion between edges
        RESETB = 1'b0;
        model_rst();
        #1;
        chk("async_resg", 32'(RESG), 32'h1);
        chk("async_tc",   32'(TC),   32'h7FFF);
        chk("async_skip", 32'(SKIP), 32'h0);
        step();
        step();
        RESETB = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            if (RESETB && $urandom_range(0, 1499) == 0) begin
                RESETB = 1'b0;
                model_rst();
            end else if (!RESETB && $urandom_range(0, 3) == 0) begin
                RESETB = 1'b1;
            end
            STM   = ($urandom_range(0, 99) == 0);
            TM_WE = ($urandom_range(0, 15) == 0);
            TM_D  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 3));
            SKIT  = ($urandom_range(0, 7) == 0);
            step();
            chk("rand_state",
                32'({RESG, TC, TC_UF, INTFT, SKIP}),
                32'({(m_rel < 2), m_tc[14:0], m_uf, m_intft, m_skip}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
